// File: rtl/sel_arbiter_pkg.sv
// sel_arbiter_pkg -- shared constants and types for the 7:1 selector arbiter.
//
// Contents:
//   NUM_REQ   number of requesters / selector inputs (7)
//   SEL_W     width of the selector code (3)
//   SEL_IDLE  selector code driven when nobody owns the selector (3'b111)
//   HOLD_W    width of the optional hold counter (8)
//   state_t   arbiter FSM states IDLE, GRANT, GAP
//   next_ptr  round-robin pointer advance with 6 -> 0 wrap
package sel_arbiter_pkg;

   localparam int NUM_REQ = 7;
   localparam int SEL_W   = 3;
   localparam int HOLD_W  = 8;

   localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Pointer moves to the slot just above the winner; the last slot wraps to 0.
   function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
      return (idx >= SEL_W'(NUM_REQ - 1)) ? '0 : idx + SEL_W'(1);
   endfunction

endpackage

// File: rtl/sel_arbiter_if.sv
// sel_arbiter_if -- request/grant bundle between requesters and sel_arbiter.
//
// Signals:
//   req    [6:0]  per-requester request, bit i asks for selector input i
//   rel           current owner finishes (release); only looked at in GRANT
//   grant  [6:0]  registered one-hot grant, all-zero when idle
//   sel    [2:0]  registered owner index, 3'b111 when idle
//   busy          high while a grant is held
//
// Handshake: a requester holds req[i] high for as long as it wants the
// selector. Ownership is visible on grant/sel one edge after the arbiter
// samples the request in IDLE. The owner keeps the selector until it pulses
// rel, drops req[i], or (timeout build) the hold limit expires; every grant
// is followed by one dead GAP cycle and one IDLE cycle before the next.
//
// Modports:
//   master  requester side (drives req/rel)
//   slave   arbiter side   (drives grant/sel/busy)
interface sel_arbiter_if import sel_arbiter_pkg::*; ();

   logic [NUM_REQ-1:0] req;
   logic               rel;
   logic [NUM_REQ-1:0] grant;
   logic [SEL_W-1:0]   sel;
   logic               busy;

   modport master (
      output req,
      output rel,
      input  grant,
      input  sel,
      input  busy
   );

   modport slave (
      input  req,
      input  rel,
      output grant,
      output sel,
      output busy
   );

endinterface

// File: rtl/sel_arbiter_rr_pick.sv
// rr_pick -- combinational rotating-priority encoder.
//
// Ports:
//   req_i     [6:0]  request vector
//   ptr_i     [2:0]  highest-priority slot for this search
//   valid_o          at least one request is set
//   winner_o  [2:0]  first set request at or above ptr_i, wrapping 6 -> 0
module rr_pick import sel_arbiter_pkg::*; (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [SEL_W-1:0]   winner_o
);

   logic [SEL_W:0] idx;
   logic           found;

   always_comb begin
      idx      = '0;
      found    = 1'b0;
      winner_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr + k never exceeds 13, so one subtraction of NUM_REQ is a full modulo.
         idx = {1'b0, ptr_i} + (SEL_W + 1)'(k);
         if (idx >= (SEL_W + 1)'(NUM_REQ)) begin
            idx = idx - (SEL_W + 1)'(NUM_REQ);
         end
         if (!found && req_i[idx[SEL_W-1:0]]) begin
            found    = 1'b1;
            winner_o = idx[SEL_W-1:0];
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/sel_arbiter.sv
// sel_arbiter -- round-robin owner selection for a shared 7:1 selector.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset
//   bus       sel_arbiter_if.slave (req, rel in; grant, sel, busy out)
//   state_o   current FSM state (debug)
//   ptr_o     round-robin pointer (debug)
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles (1..255), used only when
//             RR_SELECT_TIMEOUT_EN is defined.
//
// Build option:
//   RR_SELECT_TIMEOUT_EN  adds an 8-bit hold counter that forces the owner
//                         off after HOLD_MAX grant cycles.
//
// Behaviour: IDLE samples req and grants the rotating-priority winner at the
// next edge. GRANT holds grant/sel frozen until release, owner request drop
// or timeout, then one GAP cycle (requests ignored) returns to IDLE.
module sel_arbiter import sel_arbiter_pkg::*; #(
   parameter int HOLD_MAX = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   sel_arbiter_if.slave      bus,
   output state_t            state_o,
   output logic [SEL_W-1:0]  ptr_o
);

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("sel_arbiter: HOLD_MAX must be in 1..255");
   end

   state_t             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [SEL_W-1:0]   sel_q;
   logic               busy_q;
   logic [SEL_W-1:0]   ptr_q;
   logic [SEL_W-1:0]   ptr_d;

   logic               pick_valid;
   logic [SEL_W-1:0]   pick_winner;
   logic               owner_drop;
   logic               hold_hit;
   logic               exit_grant;

   rr_pick u_pick (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .winner_o (pick_winner)
   );

   assign ptr_d = next_ptr(pick_winner);

   // grant_q is one-hot in GRANT, so this isolates the owner's own request bit.
   assign owner_drop = ~|(bus.req & grant_q);

`ifdef RR_SELECT_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;

   assign hold_d   = hold_q + HOLD_W'(1);
   // hold_q counts completed grant cycles minus one, so the compare
   // against HOLD_MAX-1 ends the grant after exactly HOLD_MAX cycles.
   assign hold_hit = (hold_q == HOLD_W'(HOLD_MAX - 1));
`else
   assign hold_hit = 1'b0;
`endif

   assign exit_grant = bus.rel | owner_drop | hold_hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= SEL_IDLE;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
`ifdef RR_SELECT_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= GRANT;
                  grant_q <= NUM_REQ'(1) << pick_winner;
                  sel_q   <= pick_winner;
                  busy_q  <= 1'b1;
                  ptr_q   <= ptr_d;
`ifdef RR_SELECT_TIMEOUT_EN
                  hold_q  <= '0;
`endif
               end
            end
            GRANT: begin
               if (exit_grant) begin
                  state_q <= GAP;
                  grant_q <= '0;
                  sel_q   <= SEL_IDLE;
                  busy_q  <= 1'b0;
               end
`ifdef RR_SELECT_TIMEOUT_EN
               else begin
                  hold_q <= hold_d;
               end
`endif
            end
            GAP: begin
               // Single dead cycle; requests seen here are deliberately dropped.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               sel_q   <= SEL_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.busy  = busy_q;
   assign state_o   = state_q;
   assign ptr_o     = ptr_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// tb_sel_arbiter -- self-checking bench for sel_arbiter.
//
// Directed sequences for the reset, pointer, wrap, gap and reset-mid-grant
// cases, then randomized request/release/reset traffic. A cycle-level
// reference model (owner index, pointer, gap flag, grant-cycle count) predicts
// every output; predictions go through an expected queue.
module tb_sel_arbiter;
   import sel_arbiter_pkg::*;

   localparam int HOLD = 4;
   localparam int W    = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sel_arbiter_if bus ();
   state_t           dbg_state;
   logic [SEL_W-1:0] dbg_ptr;

   sel_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (bus),
      .state_o (dbg_state),
      .ptr_o   (dbg_ptr)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_owner = -1;  // -1 when nobody owns the selector
   int m_ptr   = 0;
   int m_hold  = 0;   // grant cycles completed by the current owner
   bit m_gap   = 1'b0;

   task automatic model_step(input logic [6:0] r, input logic rl, input logic rs);
      bit timeout;
      if (rs) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_gap = 1'b0;
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 7; k++) begin
            int idx;
            idx = (m_ptr + k) % 7;
            if (r[idx]) begin
               m_owner = idx;
               m_ptr   = (idx + 1) % 7;
               m_hold  = 1;
               break;
            end
         end
      end else begin
`ifdef RR_SELECT_TIMEOUT_EN
         timeout = (m_hold >= HOLD);
`else
         timeout = 1'b0;
`endif
         if (rl || !r[m_owner] || timeout) begin
            m_owner = -1;
            m_gap   = 1'b1;
         end else begin
            m_hold++;
         end
      end
   endtask

   function automatic logic [W-1:0] model_outputs();
      logic [6:0] g;
      logic [2:0] s;
      logic [1:0] st;
      g  = (m_owner >= 0) ? (7'd1 << m_owner) : 7'd0;
      s  = (m_owner >= 0) ? 3'(m_owner) : 3'd7;
      st = (m_owner >= 0) ? GRANT : (m_gap ? GAP : IDLE);
      return {st, 3'(m_ptr), (m_owner >= 0), s, g};
   endfunction

   task automatic check_outputs();
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check_eq("grant", 32'(bus.grant), 32'(e[6:0]));
      check_eq("sel",   32'(bus.sel),   32'(e[9:7]));
      check_eq("busy",  32'(bus.busy),  32'(e[10]));
      check_eq("ptr",   32'(dbg_ptr),   32'(e[13:11]));
      check_eq("state", 32'(dbg_state), 32'(e[15:14]));
      check_eq("onehot0", 32'($onehot0(bus.grant)), 32'd1);
      check_eq("sel_idle_iff_nogrant", 32'(bus.sel == 3'b111), 32'(bus.grant == 7'd0));
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [6:0] r, input logic rl, input logic rs);
      @(negedge clk);
      bus.req = r;
      bus.rel = rl;
      rst     = rs;
      model_step(r, rl, rs);
      exp_q.push_back(model_outputs());
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] r;
      bus.req = '0;
      bus.rel = 1'b0;

      // Reset, then a single request on bit 0.
      step(7'b0000000, 1'b0, 1'b1);
      check_eq("reset_sel", 32'(bus.sel), 32'h7);
      step(7'b0000001, 1'b0, 1'b0);
      check_eq("first_grant", 32'(bus.grant), 32'h01);
      check_eq("first_sel", 32'(bus.sel), 32'h0);
      check_eq("first_ptr", 32'(dbg_ptr), 32'h1);

      // Release and request drop together: one exit to GAP.
      step(7'b0000000, 1'b1, 1'b0);
      check_eq("dual_exit_busy", 32'(bus.busy), 32'h0);
      step(7'b0000000, 1'b0, 1'b0);

      // Drive ptr to 5 via a grant on bit 4, then contend bits 0 and 5.
      step(7'b0010000, 1'b0, 1'b0);
      step(7'b0010000, 1'b1, 1'b0);
      step(7'b0100001, 1'b0, 1'b0);
      check_eq("gap_ignores_req", 32'(bus.grant), 32'h0);
      step(7'b0100001, 1'b0, 1'b0);
      check_eq("ptr5_sel", 32'(bus.sel), 32'h5);
      step(7'b0100001, 1'b1, 1'b0);
      step(7'b0100001, 1'b0, 1'b0);
      step(7'b0100001, 1'b0, 1'b0);
      check_eq("wrap_sel0", 32'(bus.sel), 32'h0);
      check_eq("wrap_ptr1", 32'(dbg_ptr), 32'h1);

      // ptr=0, only bit 6: pointer wraps back to 0.
      step(7'b0000000, 1'b0, 1'b1);
      step(7'b1000000, 1'b0, 1'b0);
      check_eq("bit6_sel", 32'(bus.sel), 32'h6);
      check_eq("bit6_ptr", 32'(dbg_ptr), 32'h0);

      // Grant stays frozen while other requests toggle.
      step(7'b1111111, 1'b0, 1'b0);
      step(7'b1010101, 1'b0, 1'b0);
      check_eq("frozen_sel", 32'(bus.sel), 32'h6);

      // Reset mid-grant: grant drops at that edge, no GAP, immediate regrant allowed.
      step(7'b1000000, 1'b0, 1'b1);
      check_eq("rst_mid_busy", 32'(bus.busy), 32'h0);
      step(7'b1000000, 1'b0, 1'b0);
      check_eq("rst_regrant_busy", 32'(bus.busy), 32'h1);

      // Long hold on bit 2 with no release (timeout build ends each grant at HOLD).
      step(7'b0000000, 1'b0, 1'b1);
      repeat (14) step(7'b0000100, 1'b0, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) r = 7'd0;
         else r = 7'($urandom_range(0, 127));
         if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
         step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
- REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive cycles one requester may hold a grant (range 1..255).
- REQ-002 clock  input  1  single rising-edge clock.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 req  input  7  per-requester request; bit i requests shared 7:1 selector input i.
- REQ-005 release  input  1  current owner finishes; sampled only in GRANT.
- REQ-006 grant  output  7  one-hot grant, registered; all-zero when idle.
- REQ-007 sel  output  3  selector code, registered, MSB-first binary index of the owner; 3'b111 when idle (selector output forced 0).
- REQ-008 busy  output  1  high while in GRANT.

Function
- REQ-009 The FSM SHALL have three states: IDLE, GRANT and GAP.
- REQ-010 IDLE -> GRANT SHALL occur at the first edge where req is nonzero; grant, sel and busy SHALL update at that same edge (1-cycle latency from req to visible grant).
- REQ-011 The winner SHALL be the first set req bit at or after pointer ptr, searching upward with wrap 6 -> 0.
- REQ-012 On every grant, ptr SHALL be set to (winner+1) mod 7; 6 wraps to 0.
- REQ-013 GRANT -> GAP SHALL occur when release=1, when req[owner]=0, or when the hold limit is reached (REQ-020).
- REQ-014 GAP SHALL last exactly one cycle with grant=0, sel=3'b111, busy=0, then go to IDLE; the earliest regrant is the edge after that IDLE cycle.
- REQ-015 While in GRANT, grant and sel SHALL stay constant regardless of other req changes.
- REQ-016 If release and req[owner] drop in the same cycle, the result SHALL be a single exit to GAP with no extra effect.
- REQ-017 Code 3'b111 SHALL never be driven while grant is nonzero; grant SHALL be one-hot or zero in every cycle.
- REQ-018 Requests asserted in GAP SHALL be ignored until IDLE; only the req value sampled in IDLE decides the winner.

Reset
- REQ-019 At reset: state=IDLE, grant=0, sel=3'b111, busy=0, ptr=0, hold counter=0. Reset asserted mid-grant SHALL drop the grant at that edge with no GAP cycle.

Configuration
- REQ-020 With RR_SELECT_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on grant and increment each GRANT cycle; GRANT -> GAP SHALL be forced when it reaches HOLD_MAX-1, i.e. after HOLD_MAX cycles of grant.
- REQ-021 Without RR_SELECT_TIMEOUT_EN, there SHALL be no counter and no timeout exit; HOLD_MAX SHALL be accepted but unused.

Structure
- REQ-022 Package sel_arbiter_pkg SHALL hold NUM_REQ=7, SEL_IDLE=3'b111 and the state enum (IDLE, GRANT, GAP).
- REQ-023 Sub-module rr_pick SHALL be a combinational rotating-priority encoder (inputs req and ptr; outputs valid and winner index). All registers SHALL live in sel_arbiter.

Verification
- REQ-024 Reset, then req=7'b0000001 -> at next edge grant=7'b0000001, sel=3'b000, busy=1, ptr=1.
- REQ-025 ptr=5, req=7'b0100001 (bits 0 and 5) -> grant bit 5, sel=3'b101; after release and GAP, bit 0 wins with sel=3'b000 and ptr=1.
- REQ-026 ptr=0, only req[6] set -> sel=3'b110; next ptr=0 (wrap case).
- REQ-027 With RR_SELECT_TIMEOUT_EN and HOLD_MAX=4, req[2] held high with no release -> grant lasts exactly 4 cycles, then 1 GAP cycle with sel=3'b111, then 1 IDLE cycle, then regrant.
- REQ-028 reset pulsed during GRANT -> at that edge grant=0, sel=3'b111, busy=0, ptr=0, with no GAP cycle.
- REQ-029 All tests: assert grant is one-hot or zero every cycle, and that sel=3'b111 exactly when grant=0.
